// File: rtl/crc_pkg.sv
// Shared types, CRC presets and helpers for the parallel CRC generator.
package crc_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // CRC-8/SMBUS
    localparam logic [7:0]  CRC8_POLY    = 8'h07;
    localparam logic [7:0]  CRC8_INIT    = 8'h00;
    localparam bit          CRC8_REFIN   = 1'b0;
    localparam bit          CRC8_REFOUT  = 1'b0;
    localparam logic [7:0]  CRC8_XOROUT  = 8'h00;

    // CRC-16/CCITT-FALSE
    localparam logic [15:0] CRC16_POLY   = 16'h1021;
    localparam logic [15:0] CRC16_INIT   = 16'hFFFF;
    localparam bit          CRC16_REFIN  = 1'b0;
    localparam bit          CRC16_REFOUT = 1'b0;
    localparam logic [15:0] CRC16_XOROUT = 16'h0000;

    // CRC-32 (IEEE 802.3)
    localparam logic [31:0] CRC32_POLY   = 32'h04C11DB7;
    localparam logic [31:0] CRC32_INIT   = 32'hFFFFFFFF;
    localparam bit          CRC32_REFIN  = 1'b1;
    localparam bit          CRC32_REFOUT = 1'b1;
    localparam logic [31:0] CRC32_XOROUT = 32'hFFFFFFFF;

    // Reverses the low w bits of v; bits at and above w are returned as zero.
    function automatic logic [31:0] bit_rev(input logic [31:0] v, input int w);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < 32; i++) begin
            if (i < w) r[i] = v[w - 1 - i];
        end
        return r;
    endfunction

endpackage

// File: rtl/crc_step.sv
// Combinational CRC update for one beat: DATA_W serial steps unrolled.
module crc_step #(
    parameter int               CRC_W  = 8,
    parameter int               DATA_W = 8,
    parameter logic [CRC_W-1:0] POLY   = 8'h07,
    parameter bit               REFIN  = 1'b0
) (
    input  logic [CRC_W-1:0]  crc_in,
    input  logic [DATA_W-1:0] data,
    output logic [CRC_W-1:0]  crc_next
);

    // Fold every data bit through the LFSR in the configured bit order.
    always_comb begin
        logic [CRC_W-1:0] c;
        logic             d;
        logic             fb;
        c  = crc_in;
        d  = 1'b0;
        fb = 1'b0;
        for (int i = 0; i < DATA_W; i++) begin
            d  = REFIN ? data[i] : data[DATA_W - 1 - i];
            fb = c[CRC_W-1] ^ d;
            c  = {c[CRC_W-2:0], 1'b0};
            if (fb) c = c ^ POLY;
        end
        crc_next = c;
    end

endmodule

// File: rtl/crc_gen_par.sv
// Parallel CRC generator/checker with valid/ready input beats and a held result.
//
// state | meaning
// IDLE  | waiting for the first beat of a frame; register is at INIT
// RUN   | frame in progress, accumulating beats
// DONE  | result presented on m_valid until m_ready
module crc_gen_par
    import crc_pkg::*;
#(
    parameter int                CRC_W  = 8,
    parameter int                DATA_W = 8,
    parameter logic [CRC_W-1:0]  POLY   = 8'h07,
    parameter logic [CRC_W-1:0]  INIT   = '0,
    parameter bit                REFIN  = 1'b0,
    parameter bit                REFOUT = 1'b0,
    parameter logic [CRC_W-1:0]  XOROUT = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_last,
    input  logic [CRC_W-1:0]  chk_val,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [CRC_W-1:0]  crc_out,
    output logic              crc_ok,
    output logic              busy
);

    state_t           state;
    state_t           next_state;
    logic             rdy_q;
    logic             beat;
    logic [CRC_W-1:0] crc_q;
    logic [CRC_W-1:0] crc_base;
    logic [CRC_W-1:0] crc_next;
    logic [CRC_W-1:0] crc_refl;
    logic [CRC_W-1:0] crc_final;
    logic [CRC_W-1:0] chk_q;

    // Ready is registered so it never depends on s_valid in the same cycle,
    // and stays low while in reset until the first clock after release.
    assign s_ready = rdy_q;
    assign beat    = s_valid && rdy_q;
    assign m_valid = (state == DONE);
    assign busy    = (state == RUN);

    // First beat of a frame always starts from INIT, whatever crc_q holds.
    assign crc_base = (state == IDLE) ? INIT : crc_q;

    crc_step #(
        .CRC_W  (CRC_W),
        .DATA_W (DATA_W),
        .POLY   (POLY),
        .REFIN  (REFIN)
    ) u_step (
        .crc_in   (crc_base),
        .data     (s_data),
        .crc_next (crc_next)
    );

    // Output reflection and final XOR applied to the post-last-beat value.
    always_comb begin
        crc_refl = '0;
        for (int i = 0; i < CRC_W; i++) begin
            crc_refl[i] = crc_next[CRC_W - 1 - i];
        end
        crc_final = (REFOUT ? crc_refl : crc_next) ^ XOROUT;
    end

    // Next-state logic; clr overrides everything.
    always_comb begin
        next_state = state;
        if (clr) begin
            next_state = IDLE;
        end else begin
            unique case (state)
                IDLE, RUN: if (beat) next_state = s_last ? DONE : RUN;
                DONE:      if (m_ready) next_state = IDLE;
                default:   next_state = IDLE;
            endcase
        end
    end

    // State register and registered ready flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            rdy_q <= 1'b0;
        end else begin
            state <= next_state;
            rdy_q <= (next_state != DONE);
        end
    end

    // CRC accumulator; reloads INIT on abort and once a frame completes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            crc_q <= INIT;
        end else if (clr) begin
            crc_q <= INIT;
        end else if (beat) begin
            crc_q <= s_last ? INIT : crc_next;
        end
    end

    // Capture of the expected CRC and the result on the last beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chk_q   <= '0;
            crc_out <= '0;
            crc_ok  <= 1'b0;
        end else if (!clr && beat && s_last) begin
            chk_q   <= chk_val;
            crc_out <= crc_final;
            crc_ok  <= (crc_final == chk_val);
        end
    end

endmodule

// File: tb/tb_crc_gen_par.sv
// Directed bench for crc_gen_par: CRC-8/16/32 byte-wide instances plus a
// bit-serial instance compared against a serial LFSR.
module tb_crc_gen_par;
    import crc_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        clr;
    logic        s_valid;
    logic [7:0]  s_data;
    logic        s_last;
    logic        m_ready;
    logic [7:0]  chk8;
    logic [15:0] chk16;
    logic [31:0] chk32;

    logic        s_ready8, m_valid8, crc_ok8, busy8;
    logic [7:0]  crc_out8;
    logic        s_ready16, m_valid16, crc_ok16, busy16;
    logic [15:0] crc_out16;
    logic        s_ready32, m_valid32, crc_ok32, busy32;
    logic [31:0] crc_out32;

    logic        clr1, s_valid1, s_last1, m_ready1;
    logic [0:0]  s_data1;
    logic [7:0]  chk1;
    logic        s_ready1, m_valid1, crc_ok1, busy1;
    logic [7:0]  crc_out1;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    crc_gen_par u8 (
        .clk(clk), .rst_n(rst_n), .clr(clr), .s_valid(s_valid), .s_ready(s_ready8),
        .s_data(s_data), .s_last(s_last), .chk_val(chk8), .m_valid(m_valid8),
        .m_ready(m_ready), .crc_out(crc_out8), .crc_ok(crc_ok8), .busy(busy8)
    );

    crc_gen_par #(.CRC_W(16), .POLY(CRC16_POLY), .INIT(CRC16_INIT)) u16 (
        .clk(clk), .rst_n(rst_n), .clr(clr), .s_valid(s_valid), .s_ready(s_ready16),
        .s_data(s_data), .s_last(s_last), .chk_val(chk16), .m_valid(m_valid16),
        .m_ready(m_ready), .crc_out(crc_out16), .crc_ok(crc_ok16), .busy(busy16)
    );

    crc_gen_par #(.CRC_W(32), .POLY(CRC32_POLY), .INIT(CRC32_INIT), .REFIN(1'b1),
                  .REFOUT(1'b1), .XOROUT(CRC32_XOROUT)) u32 (
        .clk(clk), .rst_n(rst_n), .clr(clr), .s_valid(s_valid), .s_ready(s_ready32),
        .s_data(s_data), .s_last(s_last), .chk_val(chk32), .m_valid(m_valid32),
        .m_ready(m_ready), .crc_out(crc_out32), .crc_ok(crc_ok32), .busy(busy32)
    );

    crc_gen_par #(.DATA_W(1)) u1 (
        .clk(clk), .rst_n(rst_n), .clr(clr1), .s_valid(s_valid1), .s_ready(s_ready1),
        .s_data(s_data1), .s_last(s_last1), .chk_val(chk1), .m_valid(m_valid1),
        .m_ready(m_ready1), .crc_out(crc_out1), .crc_ok(crc_ok1), .busy(busy1)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] d, input logic last);
        s_valid = 1'b1;
        s_data  = d;
        s_last  = last;
        tick();
        s_valid = 1'b0;
        s_last  = 1'b0;
        s_data  = 8'hA5;
    endtask

    task automatic send_frame9();
        for (int i = 0; i < 9; i++) begin
            send(8'(8'h31 + i), (i == 8));
            if (i == 0) check("busy_in_run", busy8, 1);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, total=%0d", total);
        $fatal(1);
    end

    initial begin
        logic [7:0] model;
        logic       b;
        rst_n = 1'b0; clr = 1'b0; s_valid = 1'b0; s_data = 8'h00; s_last = 1'b0;
        m_ready = 1'b0; chk8 = 8'h00; chk16 = 16'h0; chk32 = 32'h0;
        clr1 = 1'b0; s_valid1 = 1'b0; s_last1 = 1'b0; m_ready1 = 1'b1;
        s_data1 = 1'b0; chk1 = 8'h00;

        repeat (2) tick();
        check("rst_m_valid", m_valid8, 0);
        check("rst_crc_out", crc_out8, 0);
        check("rst_crc_ok", crc_ok8, 0);
        check("rst_busy", busy8, 0);
        check("rst_crc32_out", crc_out32, 0);
        rst_n = 1'b1;
        tick();
        check("rst_s_ready", s_ready8, 1);

        // 9-beat "123456789" on all three byte-wide variants
        chk8 = 8'hF4; chk16 = 16'h29B1; chk32 = 32'hCBF43926; m_ready = 1'b1;
        send_frame9();
        check("f1_m_valid", m_valid8, 1);
        check("f1_s_ready_done", s_ready8, 0);
        check("f1_crc8", crc_out8, 8'hF4);
        check("f1_ok8", crc_ok8, 1);
        check("f1_crc16", crc_out16, 16'h29B1);
        check("f1_ok16", crc_ok16, 1);
        check("f1_crc32", crc_out32, 32'hCBF43926);
        check("f1_ok32", crc_ok32, 1);
        tick();
        check("f1_m_valid_done", m_valid8, 0);
        check("f1_s_ready_after", s_ready8, 1);

        // Single-beat frame held in DONE for 5 cycles with wrong chk_val
        m_ready = 1'b0; chk8 = 8'h00;
        send(8'h01, 1'b1);
        for (int k = 0; k < 5; k++) begin
            check("sb_m_valid_hold", m_valid8, 1);
            check("sb_crc_hold", crc_out8, 8'h07);
            check("sb_s_ready_low", s_ready8, 0);
            check("sb_crc_ok_low", crc_ok8, 0);
            tick();
        end
        m_ready = 1'b1;
        tick();
        check("sb_m_valid_clear", m_valid8, 0);
        check("sb_s_ready_back", s_ready8, 1);

        // clr while a result is pending
        m_ready = 1'b0;
        send(8'h01, 1'b1);
        check("cd_m_valid", m_valid8, 1);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check("cd_m_valid_drop", m_valid8, 0);
        check("cd_s_ready", s_ready8, 1);

        // clr mid-frame with a beat presented in the same cycle, then a clean frame
        m_ready = 1'b1;
        for (int i = 0; i < 4; i++) send(8'(8'h31 + i), 1'b0);
        check("cm_busy", busy8, 1);
        clr = 1'b1;
        send(8'hFF, 1'b1);
        clr = 1'b0;
        check("cm_m_valid", m_valid8, 0);
        check("cm_busy_idle", busy8, 0);
        send_frame9();
        check("cm_crc8", crc_out8, 8'hF4);
        check("cm_crc16", crc_out16, 16'h29B1);
        check("cm_crc32", crc_out32, 32'hCBF43926);
        tick();

        // Reset mid-frame: nothing may emerge afterwards
        for (int i = 0; i < 3; i++) send(8'(8'h31 + i), 1'b0);
        rst_n = 1'b0;
        #2;
        check("rm_busy", busy8, 0);
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            check("rm_no_m_valid", m_valid8, 0);
            tick();
        end
        check("rm_s_ready", s_ready8, 1);

        // Bit-serial instance against a serial x^8+x^2+x+1 LFSR (8 frames x 25 bits)
        for (int f = 0; f < 8; f++) begin
            model = 8'h00;
            for (int k = 0; k < 25; k++) begin
                repeat ($urandom_range(0, 2)) begin
                    s_valid1 = 1'b0;
                    s_data1  = 1'($urandom);
                    s_last1  = 1'($urandom);
                    tick();
                end
                b        = 1'($urandom_range(0, 1));
                s_valid1 = 1'b1;
                s_data1  = b;
                s_last1  = (k == 24);
                if (model[7] ^ b) model = {model[6:0], 1'b0} ^ 8'h07;
                else              model = {model[6:0], 1'b0};
                tick();
                s_valid1 = 1'b0;
                s_last1  = 1'b0;
            end
            check("ser_m_valid", m_valid1, 1);
            check("ser_crc", crc_out1, model);
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
